// File: rtl/tlu_handshake_rx.sv
// TLU trigger handshake receiver: synchronises the TLU lines, runs the
// BUSY / serial-clock handshake, and queues {timestamp, error, trigger number}
// words in a small first-word-fall-through FIFO for readout.
module tlu_handshake_rx #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int TS_WIDTH        = 16
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic        EN,
    input  logic [3:0]  TRIGGER_BITS,
    input  logic [7:0]  CLOCK_DIV,
    input  logic [15:0] TIMEOUT,
    input  logic        TLU_TRIGGER,
    input  logic        TLU_RESET,
    output logic        TLU_BUSY,
    output logic        TLU_CLOCK,
    output logic [31:0] TRIGGER_CNT,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_ACK, SHIFT_HI, SHIFT_LO, WRITE, DONE
    } state_t;

    state_t state, state_next;

    logic                trig_meta, trig_s, trig_s_d;
    logic                rst_meta, rst_s;
    logic [TS_WIDTH-1:0] ts, ts_l;
    logic [15:0]         cnt;
    logic [3:0]          idx, bits_l;
    logic [7:0]          div_l;
    logic [15:0]         tmo_l;
    logic [14:0]         sr;
    logic                err;
    logic                start, tmo_hit, half_done, last_bit;
    logic                push, pop, full;
    logic                busy_next, clk_next;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [31:0]         mem [DEPTH];

    // Half-periods shorter than 4 cycles cannot be resolved through the
    // 2-FF synchroniser, so they are raised to 4.
    function automatic logic [7:0] clamp_div(input logic [7:0] d);
        return (d < 8'd4) ? 8'd4 : d;
    endfunction

    // At least one trigger-number bit is always shifted.
    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        return (b == 4'd0) ? 4'd1 : b;
    endfunction

    assign start     = (state == IDLE) && EN && trig_s && !trig_s_d;
    assign tmo_hit   = (tmo_l != 16'd0) && (cnt == tmo_l - 16'd1);
    assign half_done = (cnt == {8'd0, div_l - 8'd1});
    assign last_bit  = (idx == bits_l - 4'd1);

    assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign FIFO_EMPTY = (wr_ptr == rd_ptr);
    assign pop        = FIFO_READ && !FIFO_EMPTY;
    assign FIFO_DATA  = FIFO_EMPTY ? 32'd0 : mem[rd_ptr[PW-2:0]];

    // Two-stage synchronisers for the asynchronous TLU lines plus edge history.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_s_d  <= 1'b0;
            rst_meta  <= 1'b0;
            rst_s     <= 1'b0;
        end else begin
            trig_meta <= TLU_TRIGGER;
            trig_s    <= trig_meta;
            trig_s_d  <= trig_s;
            rst_meta  <= TLU_RESET;
            rst_s     <= rst_meta;
        end
    end

    // Free-running timestamp and accepted-trigger counter; a TLU reset wins over an increment.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N || rst_s) begin
            ts          <= '0;
            TRIGGER_CNT <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            if (start) TRIGGER_CNT <= TRIGGER_CNT + 32'd1;
        end
    end

    // State register; BUSY and the shift clock are registered from the next state.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            state     <= IDLE;
            TLU_BUSY  <= 1'b0;
            TLU_CLOCK <= 1'b0;
        end else begin
            state     <= state_next;
            TLU_BUSY  <= busy_next;
            TLU_CLOCK <= clk_next;
        end
    end

    // Handshake sequencing and FIFO push request.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE:     if (start) state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (!trig_s)      state_next = SHIFT_HI;
                else if (tmo_hit) state_next = WRITE;
            end
            SHIFT_HI: if (half_done) state_next = SHIFT_LO;
            SHIFT_LO: if (half_done) state_next = last_bit ? WRITE : SHIFT_HI;
            WRITE: begin
                if (!full) begin
                    push       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:     if (!trig_s) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        busy_next = (state_next == WAIT_ACK) || (state_next == SHIFT_HI) ||
                    (state_next == SHIFT_LO) || (state_next == WRITE);
        clk_next  = (state_next == SHIFT_HI);
    end

    // Per-handshake working registers: latched config, cycle counter, bit index, shift register.
    always_ff @(posedge BUS_CLK) begin
        case (state)
            IDLE: begin
                if (start) begin
                    ts_l   <= ts;
                    sr     <= '0;
                    err    <= 1'b0;
                    cnt    <= '0;
                    idx    <= '0;
                    bits_l <= clamp_bits(TRIGGER_BITS);
                    div_l  <= clamp_div(CLOCK_DIV);
                    tmo_l  <= TIMEOUT;
                end
            end
            WAIT_ACK: begin
                if (!trig_s) begin
                    cnt <= '0;
                    idx <= '0;
                end else if (tmo_hit) begin
                    err <= 1'b1;
                    sr  <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
            SHIFT_HI: begin
                if (half_done) begin
                    cnt     <= '0;
                    sr[idx] <= trig_s;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
            SHIFT_LO: begin
                if (half_done) begin
                    cnt <= '0;
                    idx <= idx + 4'd1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
            default: ;
        endcase
    end

    // FIFO storage; contents need no reset because FIFO_DATA is masked while empty.
    always_ff @(posedge BUS_CLK) begin
        if (push) mem[wr_ptr[PW-2:0]] <= {ts_l, err, sr};
    end

    // FIFO pointers with a wrap bit to tell full from empty.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: tb/tb_tlu_handshake_rx.sv
// Bench for tlu_handshake_rx: a TLU master model drives the handshake, expected
// FIFO words go into a scoreboard queue at trigger time and are checked on readout.
module tb_tlu_handshake_rx;
    logic        BUS_CLK = 1'b0;
    logic        BUS_RST_N = 1'b0;
    logic        EN = 1'b0;
    logic [3:0]  TRIGGER_BITS = 4'd15;
    logic [7:0]  CLOCK_DIV = 8'd4;
    logic [15:0] TIMEOUT = 16'd0;
    logic        TLU_TRIGGER = 1'b0;
    logic        TLU_RESET = 1'b0;
    logic        FIFO_READ = 1'b0;
    logic        TLU_BUSY, TLU_CLOCK, FIFO_EMPTY;
    logic [31:0] TRIGGER_CNT, FIFO_DATA;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ts_zero = 0;
    int exp_cnt = 0;
    logic [31:0] sb[$];

    tlu_handshake_rx #(.FIFO_DEPTH_LOG2(4), .TS_WIDTH(16)) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST_N   (BUS_RST_N),
        .EN          (EN),
        .TRIGGER_BITS(TRIGGER_BITS),
        .CLOCK_DIV   (CLOCK_DIV),
        .TIMEOUT     (TIMEOUT),
        .TLU_TRIGGER (TLU_TRIGGER),
        .TLU_RESET   (TLU_RESET),
        .TLU_BUSY    (TLU_BUSY),
        .TLU_CLOCK   (TLU_CLOCK),
        .TRIGGER_CNT (TRIGGER_CNT),
        .FIFO_READ   (FIFO_READ),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_DATA   (FIFO_DATA)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Number of rising clock edges so far.
    always @(posedge BUS_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Hold reset for a few cycles, check the reset state, release it.
    task automatic do_reset(input string tag);
        @(negedge BUS_CLK);
        BUS_RST_N   = 1'b0;
        TLU_TRIGGER = 1'b0;
        FIFO_READ   = 1'b0;
        repeat (4) @(negedge BUS_CLK);
        check({tag, "_busy"},  TLU_BUSY,    0);
        check({tag, "_clk"},   TLU_CLOCK,   0);
        check({tag, "_cnt"},   TRIGGER_CNT, 0);
        check({tag, "_empty"}, FIFO_EMPTY,  1);
        check({tag, "_data"},  FIFO_DATA,   0);
        BUS_RST_N = 1'b1;
        ts_zero   = cyc;
        exp_cnt   = 0;
        sb.delete();
        repeat (3) @(negedge BUS_CLK);
    endtask

    // TLU master model. Raises TLU_TRIGGER, drops it once BUSY is seen (unless
    // hold), then presents one trigger-number bit per TLU_CLOCK rising edge.
    // Measures pulse count, BUSY length and high/low phase lengths.
    task automatic tlu_send(input logic [14:0] num, input int nbits, input bit hold,
                            input int exp_div, input int limit, input bit accept,
                            input bit en_drop, input int rst_pulse,
                            output int pulses, output int busy_len,
                            output int len_err, output bit dropped);
        int          hi, lo;
        bit          prev, seen, abort;
        logic [15:0] ts_exp;
        logic [14:0] mask, data;
        pulses = 0; busy_len = 0; len_err = 0; dropped = 1'b0;
        hi = 0; lo = 0; prev = 1'b0; seen = 1'b0; abort = 1'b0;
        data = num;
        mask = 15'((1 << nbits) - 1);
        @(negedge BUS_CLK);
        TLU_TRIGGER = 1'b1;
        ts_exp = 16'(cyc + 2 - ts_zero);
        if (accept) begin
            sb.push_back(hold ? {ts_exp, 1'b1, 15'h0} : {ts_exp, 1'b0, num & mask});
            exp_cnt++;
        end
        for (int c = 0; c < limit && !dropped && !abort; c++) begin
            @(negedge BUS_CLK);
            if (TLU_BUSY) begin
                busy_len++;
                if (!seen) begin
                    if (!hold)  TLU_TRIGGER = 1'b0;
                    if (en_drop) EN = 1'b0;
                end
                seen = 1'b1;
            end else if (seen) begin
                dropped = 1'b1;
            end
            if (TLU_CLOCK && !prev) begin
                if (pulses > 0 && lo != exp_div) len_err++;
                if (pulses == rst_pulse) begin
                    BUS_RST_N   = 1'b0;
                    TLU_TRIGGER = 1'b0;
                    abort       = 1'b1;
                end else if (!hold) begin
                    TLU_TRIGGER = data[0];
                    data        = data >> 1;
                end
                pulses++;
                hi = 0;
            end
            if (!TLU_CLOCK && prev) begin
                if (hi != exp_div) len_err++;
                lo = 0;
            end
            if (TLU_CLOCK) hi++;
            else           lo++;
            prev = TLU_CLOCK;
        end
    endtask

    // One complete unstalled handshake with the standard checks.
    task automatic run_basic(input string tag, input logic [14:0] num, input logic [3:0] bits,
                             input logic [7:0] div, input int exp_div);
        int p, b, l, n_eff, shift_len;
        bit d;
        n_eff        = (bits == 4'd0) ? 1 : int'(bits);
        shift_len    = 2 * exp_div * n_eff;
        TRIGGER_BITS = bits;
        CLOCK_DIV    = div;
        tlu_send(num, n_eff, 1'b0, exp_div, shift_len + 60, 1'b1, 1'b0, -1, p, b, l, d);
        check({tag, "_busy_drop"}, d, 1);
        check({tag, "_pulses"},    p, n_eff);
        check({tag, "_clk_len"},   l, 0);
        check({tag, "_busy_len"},  (b >= shift_len + 1) && (b <= shift_len + 8), 1);
        check({tag, "_cnt"},       TRIGGER_CNT, exp_cnt);
        TLU_TRIGGER = 1'b0;
        repeat (4) @(negedge BUS_CLK);
    endtask

    // Read every word out of the FIFO, comparing each against the scoreboard.
    task automatic drain(input string tag, output int nwords);
        logic [31:0] exp_w;
        nwords = 0;
        for (int k = 0; k < 40; k++) begin
            if (FIFO_EMPTY) break;
            check({tag, "_sb_pending"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                check({tag, "_word"}, FIFO_DATA, exp_w);
            end
            FIFO_READ = 1'b1;
            @(negedge BUS_CLK);
            FIFO_READ = 1'b0;
            nwords++;
        end
        check({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        int p, b, l, nw;
        bit d;
        logic [31:0] exp_w;

        do_reset("rst");
        EN = 1'b1;

        // Reading an empty FIFO must not disturb the pointers.
        FIFO_READ = 1'b1;
        repeat (2) @(negedge BUS_CLK);
        FIFO_READ = 1'b0;
        check("rd_empty", FIFO_EMPTY, 1);

        run_basic("basic", 15'h1234, 4'd15, 8'd4, 4);
        check("basic_busy_low", TLU_BUSY, 0);
        drain("basic", nw);
        run_basic("pat2", 15'h5AA5, 4'd15, 8'd6, 6);
        run_basic("mask8", 15'h7FFF, 4'd8, 8'd4, 4);
        drain("pat", nw);
        check("pat_words", nw, 2);

        // Timeout: TLU never releases the trigger line.
        TIMEOUT = 16'd100;
        TRIGGER_BITS = 4'd15;
        CLOCK_DIV = 8'd4;
        tlu_send(15'h0, 15, 1'b1, 4, 300, 1'b1, 1'b0, -1, p, b, l, d);
        check("tmo_busy_drop", d, 1);
        check("tmo_pulses", p, 0);
        check("tmo_busy_len", b, 101);
        TLU_TRIGGER = 1'b0;
        TIMEOUT = 16'd0;
        repeat (4) @(negedge BUS_CLK);
        drain("tmo", nw);

        // Boundary configurations.
        run_basic("bits0", 15'h7FFF, 4'd0, 8'd4, 4);
        run_basic("div1", 15'h0005, 4'd3, 8'd1, 4);
        drain("bound", nw);

        // EN dropped in WAIT_ACK; the handshake still completes.
        TRIGGER_BITS = 4'd6;
        CLOCK_DIV = 8'd4;
        tlu_send(15'h0015, 6, 1'b0, 4, 200, 1'b1, 1'b1, -1, p, b, l, d);
        check("endrop_busy_drop", d, 1);
        check("endrop_pulses", p, 6);
        TLU_TRIGGER = 1'b0;
        repeat (4) @(negedge BUS_CLK);
        tlu_send(15'h0003, 6, 1'b0, 4, 40, 1'b0, 1'b0, -1, p, b, l, d);
        check("en0_busy", b, 0);
        check("en0_pulses", p, 0);
        TLU_TRIGGER = 1'b0;
        repeat (4) @(negedge BUS_CLK);
        check("en0_cnt", TRIGGER_CNT, exp_cnt);
        drain("endrop", nw);
        check("endrop_words", nw, 1);
        EN = 1'b1;

        // TLU_RESET between triggers clears the counters and restarts the timestamp.
        @(negedge BUS_CLK);
        TLU_RESET = 1'b1;
        repeat (5) @(negedge BUS_CLK);
        check("tlurst_cnt", TRIGGER_CNT, 0);
        TLU_RESET = 1'b0;
        ts_zero = cyc + 2;
        exp_cnt = 0;
        repeat (10) @(negedge BUS_CLK);
        run_basic("tlurst", 15'h02A5, 4'd10, 8'd4, 4);
        drain("tlurst", nw);

        // Bus reset asserted during the high phase of bit 5, with a word queued.
        run_basic("pre", 15'h0011, 4'd5, 8'd4, 4);
        TRIGGER_BITS = 4'd15;
        tlu_send(15'h7FFF, 15, 1'b0, 4, 400, 1'b1, 1'b0, 5, p, b, l, d);
        check("midrst_pulses", p, 6);
        @(negedge BUS_CLK);
        check("midrst_busy", TLU_BUSY, 0);
        check("midrst_clk", TLU_CLOCK, 0);
        check("midrst_empty", FIFO_EMPTY, 1);
        check("midrst_data", FIFO_DATA, 0);
        check("midrst_cnt", TRIGGER_CNT, 0);
        BUS_RST_N = 1'b1;
        ts_zero = cyc;
        exp_cnt = 0;
        sb.delete();
        repeat (3) @(negedge BUS_CLK);
        run_basic("post", 15'h4321, 4'd15, 8'd4, 4);
        drain("post", nw);
        check("post_words", nw, 1);

        // Backpressure: 17 triggers into a 16-word FIFO with no reads.
        do_reset("bprst");
        EN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_basic("bp", 15'(i * 5 + 3), 4'd4, 8'd4, 4);
        end
        check("bp_full_nonempty", FIFO_EMPTY, 0);
        tlu_send(15'h000B, 4, 1'b0, 4, 150, 1'b1, 1'b0, -1, p, b, l, d);
        check("bp_stall_nodrop", d, 0);
        check("bp_stall_pulses", p, 4);
        check("bp_stall_busy", TLU_BUSY, 1);
        check("bp_stall_cnt", TRIGGER_CNT, 17);
        exp_w = sb.pop_front();
        check("bp_head", FIFO_DATA, exp_w);
        FIFO_READ = 1'b1;
        @(negedge BUS_CLK);
        FIFO_READ = 1'b0;
        for (int k = 0; k < 10 && TLU_BUSY; k++) @(negedge BUS_CLK);
        check("bp_release", TLU_BUSY, 0);
        TLU_TRIGGER = 1'b0;
        repeat (4) @(negedge BUS_CLK);
        drain("bp", nw);
        check("bp_words", nw, 16);
        check("bp_cnt", TRIGGER_CNT, 17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run so far", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
